// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-ported 16-bit word memory shared by an instruction
//               fetch port and a data port. One access in flight at a time,
//               fixed LATENCY cycles from acceptance to a one-cycle valid
//               pulse. The data port wins when both ports request together.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W  = 10,  // word-address bits, depth = 2**ADDR_W
    parameter int LATENCY = 4    // acceptance-to-response cycles, 2..15
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch port
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_valid,
    output logic        i_stall,
    // data port
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall
);

    localparam int                 c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);
    localparam int                 c_DEPTH    = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;

    // transaction captured at acceptance
    logic                r_port_d;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;

    logic                w_accept_d;
    logic                w_accept_i;
    logic                w_complete;

    logic [15:0]         r_mem [0:c_DEPTH-1];

    logic                r_i_valid;
    logic                r_d_valid;
    logic [15:0]         r_i_rdata;
    logic [15:0]         r_d_rdata;

    // Byte-address bit 0 and bits above the word address are intentionally
    // dropped; folding the full buses here keeps them visibly consumed.
    logic                w_unused;
    assign w_unused = ^{i_addr, d_addr};

    // Next-state decode: arbitration in IDLE, completion detect in BUSY.
    always_comb begin
        w_state_next = r_state;
        w_accept_d   = 1'b0;
        w_accept_i   = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req) begin
                    w_accept_d   = 1'b1;
                    w_state_next = ST_BUSY;
                end else if (i_req) begin
                    w_accept_i   = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latency down-counter: loaded at acceptance, counts down while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept_d || w_accept_i) begin
            r_cnt <= c_CNT_LOAD;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - c_CNT_LAST;
        end
    end

    // Capture the winning request; inputs are ignored until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_port_d <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept_d || w_accept_i) begin
            r_port_d <= w_accept_d;
            r_wr     <= w_accept_d & d_wr;
            r_addr   <= w_accept_d ? d_addr[ADDR_W:1] : i_addr[ADDR_W:1];
            r_wdata  <= d_wdata;
        end
    end

    // Memory array write on the completing edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_complete && r_port_d && r_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Response registers: one-cycle valid, read data held until next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            if (w_complete) begin
                if (r_port_d) begin
                    r_d_valid <= 1'b1;
                    if (!r_wr) begin
                        r_d_rdata <= r_mem[r_addr];
                    end
                end else begin
                    r_i_valid <= 1'b1;
                    r_i_rdata <= r_mem[r_addr];
                end
            end
        end
    end

    assign i_valid = r_i_valid;
    assign d_valid = r_d_valid;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_stall = i_req & ~r_i_valid;
    assign d_stall = d_req & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. Stimulus pushes expected
//               (cycle, data) entries; a negedge monitor pops and compares on
//               every valid pulse. Covers LATENCY=4 and LATENCY=2 builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // queue index: 0 = i port, 1 = d port, 2 = d port of LATENCY=2 build,
    // 3 = i port of LATENCY=2 build (never expected to fire)
    sb_t         q [4][$];

    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata;
    logic        i_valid, d_valid, i_stall, d_stall;

    logic        d2_req, d2_wr, i2_req;
    logic [15:0] d2_addr, d2_wdata, i2_addr;
    logic [15:0] d2_rdata, i2_rdata;
    logic        d2_valid, i2_valid, d2_stall, i2_stall;

    mem_responder #(.ADDR_W(10), .LATENCY(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall)
    );

    mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i2_req), .i_addr(i2_addr), .i_rdata(i2_rdata),
        .i_valid(i2_valid), .i_stall(i2_stall),
        .d_req(d2_req), .d_wr(d2_wr), .d_addr(d2_addr), .d_wdata(d2_wdata),
        .d_rdata(d2_rdata), .d_valid(d2_valid), .d_stall(d2_stall)
    );

    always #5 clk = ~clk;

    // cycle index: increments on each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, got, exp);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [15:0] data,
                       input string nm);
        sb_t e;
        if (v) begin
            if (q[p].size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_unexpected_valid: got valid at cycle %0d required none", nm, cyc);
            end else begin
                e = q[p].pop_front();
                check({nm, "_rdata"}, {16'h0, data}, {16'h0, e.data});
                check({nm, "_valid_cycle"}, cyc, e.cyc);
            end
        end else if (q[p].size() > 0 && q[p][0].cyc < cyc) begin
            e = q[p].pop_front();
            total++;
            bad++;
            $display("FAIL %s_missed_valid: got no valid by cycle %0d required at %0d", nm, cyc, e.cyc);
        end
    endtask

    // Monitor: responses against the scoreboard, stall against its definition.
    always @(negedge clk) begin
        mon(0, i_valid,  i_rdata,  "i");
        mon(1, d_valid,  d_rdata,  "d");
        mon(2, d2_valid, d2_rdata, "d2");
        mon(3, i2_valid, i2_rdata, "i2");
        check("i_stall",  {31'h0, i_stall},  {31'h0, i_req  & ~i_valid});
        check("d_stall",  {31'h0, d_stall},  {31'h0, d_req  & ~d_valid});
        check("d2_stall", {31'h0, d2_stall}, {31'h0, d2_req & ~d2_valid});
    end

    // One data-port access on the LATENCY=4 build; returns in the valid cycle.
    task automatic d_op(input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp);
        sb_t e;
        e.cyc  = cyc + 4;
        e.data = exp;
        q[1].push_back(e);
        d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (d_valid) break;
        end
        if (!d_valid) check("d_timeout", 32'h0, 32'h1);
        d_req = 1'b0; d_wr = 1'b0;
    endtask

    task automatic d2_op(input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp);
        sb_t e;
        e.cyc  = cyc + 2;
        e.data = exp;
        q[2].push_back(e);
        d2_req = 1'b1; d2_wr = wr; d2_addr = addr; d2_wdata = wdata;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (d2_valid) break;
        end
        if (!d2_valid) check("d2_timeout", 32'h0, 32'h1);
        d2_req = 1'b0; d2_wr = 1'b0;
    endtask

    // Main directed stimulus.
    initial begin
        sb_t e;
        int  n;
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        i2_req = 1'b0; i2_addr = '0; d2_req = 1'b0; d2_wr = 1'b0; d2_addr = '0; d2_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_i_rdata",  {16'h0, i_rdata},  32'h0);
        check("rst_d_rdata",  {16'h0, d_rdata},  32'h0);
        check("rst_i_valid",  {31'h0, i_valid},  32'h0);
        check("rst_d_valid",  {31'h0, d_valid},  32'h0);
        check("rst_d2_rdata", {16'h0, d2_rdata}, 32'h0);

        // write then read; write leaves d_rdata at its previous value
        d_op(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        d_op(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        d_op(1'b1, 16'h0000, 16'h1111, 16'hBEEF);
        d_op(1'b1, 16'h0002, 16'h2222, 16'hBEEF);
        d_op(1'b1, 16'h0004, 16'h3333, 16'hBEEF);
        repeat (2) @(posedge clk);
        #1;

        // simultaneous requests: d first, i waits for it
        e.cyc = cyc + 4; e.data = 16'hBEEF; q[1].push_back(e);
        e.cyc = cyc + 8; e.data = 16'h1111; q[0].push_back(e);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
        i_req = 1'b1; i_addr = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (d_valid) d_req = 1'b0;
            if (i_valid) break;
        end
        if (!i_valid) check("i_timeout", 32'h0, 32'h1);
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // back-to-back fetches with i_req held high
        e.cyc = cyc + 4;  e.data = 16'h1111; q[0].push_back(e);
        e.cyc = cyc + 8;  e.data = 16'h2222; q[0].push_back(e);
        e.cyc = cyc + 12; e.data = 16'h3333; q[0].push_back(e);
        i_req = 1'b1; i_addr = 16'h0000;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (i_valid) begin
                n++;
                if (n == 1) i_addr = 16'h0002;
                else if (n == 2) i_addr = 16'h0004;
                else break;
            end
        end
        check("fetch_count", n, 3);
        i_req = 1'b0;

        // aliasing: upper bits and byte bit 0 are ignored
        d_op(1'b1, 16'h0802, 16'h1234, 16'hBEEF);
        d_op(1'b0, 16'h0002, 16'h0000, 16'h1234);
        d_op(1'b0, 16'h0003, 16'h0000, 16'h1234);
        check("i_rdata_hold", {16'h0, i_rdata}, 32'h3333);

        // reset mid-write aborts the write and suppresses d_valid
        d_op(1'b1, 16'h0020, 16'hAAAA, 16'h1234);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_d_rdata", {16'h0, d_rdata}, 32'h0);
        check("abort_i_rdata", {16'h0, i_rdata}, 32'h0);
        check("abort_d_valid", {31'h0, d_valid}, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        d_op(1'b0, 16'h0020, 16'h0000, 16'hAAAA);

        // LATENCY=2 build
        d2_op(1'b1, 16'h0006, 16'h0BAD, 16'h0000);
        d2_op(1'b0, 16'h0006, 16'h0000, 16'h0BAD);

        repeat (8) @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) check("sb_empty", q[p].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by cycle %0d required earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
